// File: rtl/multicycle_alu_if.sv
// Handshake + operand/result bundle for multicycle_alu.
// slave = the ALU, master = the producer/consumer driving it.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             illegal;

  modport slave (
    input  in_valid, op1, op2, alu_op, out_ready,
    output in_ready, out_valid, result, zero, neg, ovf, illegal
  );

  modport master (
    output in_valid, op1, op2, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, neg, ovf, illegal
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative
// shift-add signed multiply (WIDTH iterations), valid/ready handshake.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_LRS  = 4'b0000;
  localparam logic [3:0] OP_LLS  = 4'b0001;
  localparam logic [3:0] OP_ARS  = 4'b0010;
  localparam logic [3:0] OP_ALS  = 4'b0011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;

  logic               accept;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, alu_ill;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] acc_nxt, prod;

  // Magnitude kept as WIDTH-bit unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign bus.in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = ill_q;

  assign sum     = bus.op1 + bus.op2;
  assign diff    = bus.op1 - bus.op2;
  assign sh      = bus.op2[SHW-1:0];
  // Last iteration's accumulate is folded into the finalize so the
  // product lands on the WIDTH-th iteration edge.
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod    = sgn_q ? (~acc_nxt + 1'b1) : acc_nxt;

  // Single-cycle datapath evaluated on the live inputs at the accept edge.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_op)
      OP_AND:  alu_res = bus.op1 & bus.op2;
      OP_OR:   alu_res = bus.op1 | bus.op2;
      OP_NOR:  alu_res = ~(bus.op1 | bus.op2);
      OP_NAND: alu_res = ~(bus.op1 & bus.op2);
      OP_XOR:  alu_res = bus.op1 ^ bus.op2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      OP_LRS:  alu_res = bus.op1 >> sh;
      OP_ARS:  alu_res = WIDTH'($signed(bus.op1) >>> sh);
      OP_LLS, OP_ALS: begin
        alu_res = bus.op1 << sh;
        alu_ovf = alu_res[WIDTH-1] != bus.op1[WIDTH-1];
      end
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state / datapath control for IDLE -> (BUSY) -> DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    case (state_q)
      BUSY: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = prod[WIDTH-1:0];
          zero_d   = (prod[WIDTH-1:0] == '0);
          neg_d    = prod[WIDTH-1];
          ovf_d    = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
          ill_d    = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          if (bus.alu_op == OP_MUL) begin
            state_d  = BUSY;
            mcand_d  = {{WIDTH{1'b0}}, mag(bus.op1)};
            mplier_d = mag(bus.op2);
            acc_d    = '0;
            cnt_d    = '0;
            sgn_d    = bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1];
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers; reset aborts any multiply and clears result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
    end
  end
endmodule
